// File: rtl/bus_keeper_pkg.sv
// Shared types and helpers for the bus keeper / arbiter.
//   keep_state_t : keeper state as seen on the state_dbg port
//   popcount     : number of set bits in a driver-enable vector
//   idx_width    : width of a driver index (at least 1 bit)
package bus_keeper_pkg;

  typedef enum logic [1:0] {
    DRIVEN  = 2'd0,
    HOLD    = 2'd1,
    STALE   = 2'd2,
    CONTEND = 2'd3
  } keep_state_t;

  // Widest driver-enable vector popcount accepts; NDRV must not exceed this.
  localparam int MAX_DRV = 64;

  function automatic int idx_width(input int ndrv);
    return (ndrv > 1) ? $clog2(ndrv) : 1;
  endfunction

  // Index width for the default four-driver configuration.
  localparam int NDRV_DEFAULT = 4;
  localparam int IDX_W = idx_width(NDRV_DEFAULT);

  function automatic int popcount(input logic [MAX_DRV-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_DRV; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bus_keeper_sel.sv
// Combinational driver resolution.
//   drv_en    : per-driver enable
//   drv_data  : packed driver data, driver i at [i*WIDTH +: WIDTH]
//   n_zero    : no driver enabled
//   n_one     : exactly one driver enabled
//   n_multi   : two or more drivers enabled
//   sel_idx   : index of the lowest enabled driver (meaningful when n_one)
//   sel_data  : data of that driver; zero when nothing is enabled
module bus_keeper_sel
  import bus_keeper_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDRV  = 4,
  parameter int SEL_W = 2
) (
  input  logic [NDRV-1:0]       drv_en,
  input  logic [NDRV*WIDTH-1:0] drv_data,
  output logic                  n_zero,
  output logic                  n_one,
  output logic                  n_multi,
  output logic [SEL_W-1:0]      sel_idx,
  output logic [WIDTH-1:0]      sel_data
);

  int n;

  always_comb begin
    n       = popcount(MAX_DRV'(drv_en));
    n_zero  = (n == 0);
    n_one   = (n == 1);
    n_multi = (n > 1);
    sel_idx  = '0;
    sel_data = '0;
    // Only enabled drivers are looked at, so X on a disabled driver's data
    // never reaches sel_data. Descending scan leaves the lowest index selected.
    for (int i = NDRV - 1; i >= 0; i--) begin
      if (drv_en[i]) begin
        sel_idx  = SEL_W'(i);
        sel_data = drv_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/bus_keeper_arb.sv
// Clocked bus keeper with driver arbitration flags.
// Resolves NDRV enable/data drivers onto a WIDTH-bit bus, holds the last
// solely-driven value while the bus floats, flags float timeout and
// multi-driver contention. There is no valid/ready handshake: every rising CK
// samples the drivers and all outputs update one cycle later.
//   CK, RN        : clock (rising edge), async active-low reset
//   drv_en        : per-driver output enable
//   drv_data      : driver i data at [i*WIDTH +: WIDTH]
//   clr           : synchronous clear of cont_cnt (wins over a contention cycle)
//   bus_out       : resolved / held bus value
//   owner         : index of the last sole driver
//   keep_active   : keeper holding (state != DRIVEN)
//   float_timeout : bus has floated for >= TIMEOUT cycles
//   contention    : more than one driver was enabled in the previous cycle
//   cont_cnt      : saturating count of contention cycles
//   state_dbg     : current keeper state
module bus_keeper_arb
  import bus_keeper_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NDRV      = 4,
  parameter int               TIMEOUT   = 16,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               DECAY_EN  = 1'b0,
  parameter logic [WIDTH-1:0] DECAY_VAL = '0,
  localparam int              OWNER_W   = idx_width(NDRV)
) (
  input  logic                  CK,
  input  logic                  RN,
  input  logic [NDRV-1:0]       drv_en,
  input  logic [NDRV*WIDTH-1:0] drv_data,
  input  logic                  clr,
  output logic [WIDTH-1:0]      bus_out,
  output logic [OWNER_W-1:0]    owner,
  output logic                  keep_active,
  output logic                  float_timeout,
  output logic                  contention,
  output logic [CNT_W-1:0]      cont_cnt,
  output keep_state_t           state_dbg
);

  // float_cnt saturates at TIMEOUT, so it needs to represent TIMEOUT itself.
  localparam int               FC_W   = $clog2(TIMEOUT + 1);
  localparam logic [FC_W-1:0]  FC_MAX = FC_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CC_MAX = '1;

  logic               n_zero, n_one, n_multi;
  logic [OWNER_W-1:0] sel_idx;
  logic [WIDTH-1:0]   sel_data;

  keep_state_t        state_q, state_d;
  logic [FC_W-1:0]    float_cnt_q, float_cnt_d;
  logic [WIDTH-1:0]   bus_d;
  logic [OWNER_W-1:0] owner_d;
  logic               float_timeout_d, contention_d;
  logic [CNT_W-1:0]   cont_cnt_d;

  bus_keeper_sel #(
    .WIDTH (WIDTH),
    .NDRV  (NDRV),
    .SEL_W (OWNER_W)
  ) u_sel (
    .drv_en   (drv_en),
    .drv_data (drv_data),
    .n_zero   (n_zero),
    .n_one    (n_one),
    .n_multi  (n_multi),
    .sel_idx  (sel_idx),
    .sel_data (sel_data)
  );

  always_comb begin
    state_d         = state_q;
    float_cnt_d     = float_cnt_q;
    bus_d           = bus_out;
    owner_d         = owner;
    float_timeout_d = float_timeout;
    contention_d    = contention;
    cont_cnt_d      = cont_cnt;
    if (n_one) begin
      state_d         = DRIVEN;
      bus_d           = sel_data;
      owner_d         = sel_idx;
      float_cnt_d     = '0;
      float_timeout_d = 1'b0;
      contention_d    = 1'b0;
    end else if (n_multi) begin
      state_d         = CONTEND;
      contention_d    = 1'b1;
      float_cnt_d     = '0;
      float_timeout_d = 1'b0;
      if (cont_cnt != CC_MAX) cont_cnt_d = cont_cnt + CNT_W'(1);
    end else if (n_zero) begin
      contention_d = 1'b0;
      if (float_cnt_q == FC_MAX) begin
        // Already timed out: everything is held.
        state_d = STALE;
      end else begin
        float_cnt_d = float_cnt_q + FC_W'(1);
        if (float_cnt_d == FC_MAX) begin
          // Entry into STALE happens exactly once per float episode, so the
          // decay pattern is loaded only here.
          state_d         = STALE;
          float_timeout_d = 1'b1;
          if (DECAY_EN) bus_d = DECAY_VAL;
        end else begin
          state_d = HOLD;
        end
      end
    end
    if (clr) cont_cnt_d = '0;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q       <= HOLD;
      float_cnt_q   <= '0;
      bus_out       <= RESET_VAL;
      owner         <= '0;
      float_timeout <= 1'b0;
      contention    <= 1'b0;
      cont_cnt      <= '0;
    end else begin
      state_q       <= state_d;
      float_cnt_q   <= float_cnt_d;
      bus_out       <= bus_d;
      owner         <= owner_d;
      float_timeout <= float_timeout_d;
      contention    <= contention_d;
      cont_cnt      <= cont_cnt_d;
    end
  end

  assign keep_active = (state_q != DRIVEN);
  assign state_dbg   = state_q;

endmodule
